// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice-Boltzmann definitions. The collider and the streamer both
// import this package: direction indices, velocity tables, opposite-direction
// lookup, the Q3.13 word width and the streamer FSM state type.
package lbm_pkg;

   localparam int Q_W   = 16;
   localparam int N_DIR = 9;

   localparam logic [3:0] D_NULL = 4'd0;
   localparam logic [3:0] D_N    = 4'd1;
   localparam logic [3:0] D_NE   = 4'd2;
   localparam logic [3:0] D_E    = 4'd3;
   localparam logic [3:0] D_SE   = 4'd4;
   localparam logic [3:0] D_S    = 4'd5;
   localparam logic [3:0] D_SW   = 4'd6;
   localparam logic [3:0] D_W    = 4'd7;
   localparam logic [3:0] D_NW   = 4'd8;

   typedef enum logic {ST_IDLE, ST_EMIT} stream_state_t;

   // x velocity component; +x is east
   function automatic logic signed [1:0] dir_cx(input logic [3:0] d);
      case (d)
         D_NE, D_E, D_SE: dir_cx = 2'sd1;
         D_SW, D_W, D_NW: dir_cx = -2'sd1;
         default:         dir_cx = 2'sd0;
      endcase
   endfunction

   // y velocity component; +y is north
   function automatic logic signed [1:0] dir_cy(input logic [3:0] d);
      case (d)
         D_N, D_NE, D_NW: dir_cy = 2'sd1;
         D_SE, D_S, D_SW: dir_cy = -2'sd1;
         default:         dir_cy = 2'sd0;
      endcase
   endfunction

   // Opposite population: rest maps to itself, moving ones rotate by four
   function automatic logic [3:0] dir_opposite(input logic [3:0] d);
      if (d == D_NULL || d > D_NW) begin
         dir_opposite = D_NULL;
      end else begin
         dir_opposite = 4'(((int'(d) + 3) % 8) + 1);
      end
   endfunction

endpackage

// File: rtl/lattice_streamer_if.sv
// Cell-input and memory-write handshake bundle of the lattice streamer.
// master: the streamer itself; slave: the collider / memory side.
interface lattice_streamer_if
   import lbm_pkg::*;
#(
   parameter int COORD_W = 8,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = Q_W
);
   logic                in_valid;
   logic                in_ready;
   logic [COORD_W-1:0]  cell_x;
   logic [COORD_W-1:0]  cell_y;
   logic [DATA_W-1:0]   f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw;
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                cell_done;
   logic                err_coord;

   modport master (
      input  in_valid, cell_x, cell_y,
      input  f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw,
      input  wr_ready,
      output in_ready, wr_valid, wr_addr, wr_data, cell_done, err_coord
   );

   modport slave (
      output in_valid, cell_x, cell_y,
      output f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw,
      output wr_ready,
      input  in_ready, wr_valid, wr_addr, wr_data, cell_done, err_coord
   );
endinterface

// File: rtl/lattice_stream_addr.sv
// Combinational target mapper: (x, y, d) -> {word address, bounce flag}.
// Default: a neighbour outside the lattice bounces back into the source cell's
// opposite slot. With LATTICE_STREAMER_PERIODIC_EN defined the neighbour wraps
// around the lattice instead and keeps slot d.
module lattice_stream_addr
   import lbm_pkg::*;
#(
   parameter int LATTICE_WIDTH  = 64,
   parameter int LATTICE_HEIGHT = 64,
   parameter int COORD_W        = 8,
   parameter int ADDR_W         = 16
)
(
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic [3:0]         i_d,
   output logic [ADDR_W-1:0]  o_addr,
   output logic               o_bounce
);
   // two spare bits: one for the sign, one so x+1 never overflows
   localparam int SW = COORD_W + 2;
   localparam logic signed [SW-1:0] L_W = SW'(LATTICE_WIDTH);
   localparam logic signed [SW-1:0] L_H = SW'(LATTICE_HEIGHT);

   logic signed [1:0]    w_cx, w_cy;
   logic signed [SW-1:0] w_nx, w_ny;
   logic                 w_out_x, w_out_y;
   logic [COORD_W-1:0]   w_tx, w_ty;
   logic [3:0]           w_slot;
   logic [ADDR_W-1:0]    w_cell;

   assign w_cx    = dir_cx(i_d);
   assign w_cy    = dir_cy(i_d);
   assign w_nx    = $signed({2'b00, i_x}) + $signed({{COORD_W{w_cx[1]}}, w_cx});
   assign w_ny    = $signed({2'b00, i_y}) + $signed({{COORD_W{w_cy[1]}}, w_cy});
   assign w_out_x = w_nx[SW-1] || (w_nx >= L_W);
   assign w_out_y = w_ny[SW-1] || (w_ny >= L_H);

   // Pick the target cell and slot for this population
   always_comb begin
      w_tx     = i_x;
      w_ty     = i_y;
      w_slot   = i_d;
      o_bounce = 1'b0;
`ifdef LATTICE_STREAMER_PERIODIC_EN
      // a step can only leave by one cell, so -1 wraps to W-1 and W wraps to 0
      if (w_out_x) w_tx = w_nx[SW-1] ? COORD_W'(LATTICE_WIDTH - 1) : '0;
      else         w_tx = w_nx[COORD_W-1:0];
      if (w_out_y) w_ty = w_ny[SW-1] ? COORD_W'(LATTICE_HEIGHT - 1) : '0;
      else         w_ty = w_ny[COORD_W-1:0];
`else
      if (w_out_x || w_out_y) begin
         w_slot   = dir_opposite(i_d);
         o_bounce = 1'b1;
      end else begin
         w_tx = w_nx[COORD_W-1:0];
         w_ty = w_ny[COORD_W-1:0];
      end
`endif
   end

   // cell index uses a constant row stride; the *9 is a shift-and-add
   assign w_cell = ADDR_W'(w_ty) * ADDR_W'(LATTICE_WIDTH) + ADDR_W'(w_tx);
   assign o_addr = (w_cell << 3) + w_cell + ADDR_W'(w_slot);

endmodule

// File: rtl/lattice_streamer.sv
// D2Q9 streaming stage: latches one post-collision cell and issues its nine
// population writes (d = 0..8) to the neighbouring cells in the distribution
// memory. Edge handling is bounce-back by default; define
// LATTICE_STREAMER_PERIODIC_EN for periodic wrap-around (see lattice_stream_addr).
module lattice_streamer
   import lbm_pkg::*;
#(
   parameter int LATTICE_WIDTH  = 64,
   parameter int LATTICE_HEIGHT = 64,
   parameter int COORD_W        = 8,
   parameter int ADDR_W         = 16
)
(
   input  logic               clk,
   input  logic               rst,
   lattice_streamer_if.master bus
);
   localparam int CW1 = COORD_W + 1;

   stream_state_t       r_state;
   logic [3:0]          r_d;
   logic [COORD_W-1:0]  r_x, r_y;
   logic [Q_W-1:0]      r_f [N_DIR];
   logic                r_wr_valid;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [Q_W-1:0]      r_wr_data;
   logic                r_err;

   logic                w_accept, w_in_range, w_wr_fire, w_last;
   logic [3:0]          w_dn, w_ad;
   logic [COORD_W-1:0]  w_ax, w_ay;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_bounce;
   logic [Q_W-1:0]      w_next_data;

   assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
   assign bus.wr_valid  = r_wr_valid;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_data   = r_wr_data;
   assign bus.err_coord = r_err;

   assign w_accept   = bus.in_valid && bus.in_ready;
   assign w_in_range = ({1'b0, bus.cell_x} < CW1'(LATTICE_WIDTH)) &&
                       ({1'b0, bus.cell_y} < CW1'(LATTICE_HEIGHT));
   assign w_wr_fire  = r_wr_valid && bus.wr_ready;
   assign w_last     = (r_d == D_NW);
   assign w_dn       = r_d + 4'd1;

   // done is tied to the acceptance of the last write, not to a later register stage
   assign bus.cell_done = w_wr_fire && w_last && !rst;

   // In IDLE the mapper looks at the incoming cell so slot 0 is ready on the next
   // edge; in EMIT it looks one direction ahead of the write being presented.
   assign w_ax = (r_state == ST_IDLE) ? bus.cell_x : r_x;
   assign w_ay = (r_state == ST_IDLE) ? bus.cell_y : r_y;
   assign w_ad = (r_state == ST_IDLE) ? D_NULL : w_dn;

   lattice_stream_addr #(
      .LATTICE_WIDTH  (LATTICE_WIDTH),
      .LATTICE_HEIGHT (LATTICE_HEIGHT),
      .COORD_W        (COORD_W),
      .ADDR_W         (ADDR_W)
   ) u_addr (
      .i_x      (w_ax),
      .i_y      (w_ay),
      .i_d      (w_ad),
      .o_addr   (w_addr),
      .o_bounce (w_bounce)
   );

   // Population that follows the one currently on the write port
   always_comb begin
      w_next_data = '0;
      if (w_dn < 4'(N_DIR)) w_next_data = r_f[w_dn];
   end

   // Register bank: capture the accepted cell (data path, not reset)
   always_ff @(posedge clk) begin
      if (w_accept && w_in_range) begin
         r_x           <= bus.cell_x;
         r_y           <= bus.cell_y;
         r_f[D_NULL]   <= bus.f_null;
         r_f[D_N]      <= bus.f_n;
         r_f[D_NE]     <= bus.f_ne;
         r_f[D_E]      <= bus.f_e;
         r_f[D_SE]     <= bus.f_se;
         r_f[D_S]      <= bus.f_s;
         r_f[D_SW]     <= bus.f_sw;
         r_f[D_W]      <= bus.f_w;
         r_f[D_NW]     <= bus.f_nw;
      end
   end

   // IDLE/EMIT sequencer with registered write port and sticky coordinate error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_d        <= D_NULL;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_in_range) begin
                     r_state    <= ST_EMIT;
                     r_d        <= D_NULL;
                     r_wr_valid <= 1'b1;
                     r_wr_addr  <= w_addr;
                     r_wr_data  <= bus.f_null;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (w_wr_fire) begin
                  if (w_last) begin
                     r_state    <= ST_IDLE;
                     r_d        <= D_NULL;
                     r_wr_valid <= 1'b0;
                  end else begin
                     r_d       <= w_dn;
                     r_wr_addr <= w_addr;
                     r_wr_data <= w_next_data;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lattice_streamer.sv
// Directed bench for lattice_streamer on a 4x4 lattice. Expected addresses are
// hand-derived from addr = (y*4 + x)*9 + d; corner expectations follow
// LATTICE_STREAMER_PERIODIC_EN when that macro is defined.
module tb_lattice_streamer;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int CW = 8;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lattice_streamer_if #(.COORD_W(CW), .ADDR_W(AW)) bus();

   lattice_streamer #(
      .LATTICE_WIDTH  (W),
      .LATTICE_HEIGHT (H),
      .COORD_W        (CW),
      .ADDR_W         (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] fv [9];
   int          ex [9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_f(input logic [15:0] base);
      for (int d = 0; d < 9; d++) fv[d] = base + 16'(d);
   endtask

   task automatic send_cell(input string tag, input int x, input int y);
      int guard;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.cell_x = 8'(x);
      bus.cell_y = 8'(y);
      bus.f_null = fv[0]; bus.f_n  = fv[1]; bus.f_ne = fv[2];
      bus.f_e    = fv[3]; bus.f_se = fv[4]; bus.f_s  = fv[5];
      bus.f_sw   = fv[6]; bus.f_w  = fv[7]; bus.f_nw = fv[8];
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   // Walk the nine writes against ex[]/fv[]; optionally stall for 3 cycles at one d
   task automatic collect(input string tag, input int stall_at);
      int guard;
      for (int k = 0; k < 9; k++) begin
         guard = 0;
         while (bus.wr_valid !== 1'b1 && guard < 20) begin
            step();
            guard++;
         end
         chk($sformatf("%s_gap_d%0d", tag, k), 32'(guard), 32'd0);
         chk($sformatf("%s_addr_d%0d", tag, k), 32'(bus.wr_addr), 32'(ex[k]));
         chk($sformatf("%s_data_d%0d", tag, k), 32'(bus.wr_data), 32'(fv[k]));
         chk($sformatf("%s_inrdy_d%0d", tag, k), 32'(bus.in_ready), 32'd0);
         if (k == stall_at) begin
            bus.wr_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               chk($sformatf("%s_hold_valid_%0d", tag, s), 32'(bus.wr_valid), 32'd1);
               chk($sformatf("%s_hold_addr_%0d", tag, s), 32'(bus.wr_addr), 32'(ex[k]));
               chk($sformatf("%s_hold_data_%0d", tag, s), 32'(bus.wr_data), 32'(fv[k]));
               chk($sformatf("%s_hold_done_%0d", tag, s), 32'(bus.cell_done), 32'd0);
               chk($sformatf("%s_hold_inrdy_%0d", tag, s), 32'(bus.in_ready), 32'd0);
            end
            bus.wr_ready = 1'b1;
         end
         chk($sformatf("%s_done_d%0d", tag, k), 32'(bus.cell_done), (k == 8) ? 32'd1 : 32'd0);
         step();
      end
      chk({tag, "_end_valid"}, 32'(bus.wr_valid), 32'd0);
      chk({tag, "_end_done"}, 32'(bus.cell_done), 32'd0);
      chk({tag, "_end_inrdy"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.cell_x   = '0;
      bus.cell_y   = '0;
      bus.f_null = '0; bus.f_n  = '0; bus.f_ne = '0;
      bus.f_e    = '0; bus.f_se = '0; bus.f_s  = '0;
      bus.f_sw   = '0; bus.f_w  = '0; bus.f_nw = '0;
      bus.wr_ready = 1'b1;

      // reset state
      step();
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_cell_done", 32'(bus.cell_done), 32'd0);
      chk("rst_err", 32'(bus.err_coord), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // interior cell (1,1): all nine neighbours exist
      load_f(16'h0100);
      fv[3] = 16'h0123;
      ex = '{45, 82, 92, 57, 22, 14, 6, 43, 80};
      send_cell("int", 1, 1);
      collect("int", -1);

      // corner (0,0): five populations leave the lattice
      load_f(16'h0400);
      fv[6] = 16'h0456;
`ifdef LATTICE_STREAMER_PERIODIC_EN
      ex = '{0, 37, 47, 12, 121, 113, 141, 34, 71};
`else
      ex = '{0, 37, 47, 12, 8, 1, 2, 3, 4};
`endif
      send_cell("corner", 0, 0);
      collect("corner", -1);

      // backpressure on d=4 for cell (2,1)
      load_f(16'h0A00);
      ex = '{54, 91, 101, 66, 31, 23, 15, 52, 89};
      send_cell("bp", 2, 1);
      collect("bp", 4);

      // out-of-range cell: flag only, no writes
      load_f(16'h0E00);
      send_cell("badx", 4, 0);
      chk("badx_err", 32'(bus.err_coord), 32'd1);
      chk("badx_valid", 32'(bus.wr_valid), 32'd0);
      chk("badx_inrdy", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) step();
      chk("badx_valid_later", 32'(bus.wr_valid), 32'd0);
      chk("badx_err_sticky", 32'(bus.err_coord), 32'd1);
      send_cell("bady", 0, 4);
      chk("bady_valid", 32'(bus.wr_valid), 32'd0);
      chk("bady_err", 32'(bus.err_coord), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("err_cleared", 32'(bus.err_coord), 32'd0);

      // reset after the third write is accepted
      load_f(16'h0C00);
      ex = '{45, 82, 92, 57, 22, 14, 6, 43, 80};
      send_cell("mrst", 1, 1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("mrst_addr_d%0d", k), 32'(bus.wr_addr), 32'(ex[k]));
         step();
      end
      chk("mrst_valid_before", 32'(bus.wr_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_inrdy_in_rst", 32'(bus.in_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(bus.wr_valid), 32'd0);
      chk("mrst_addr", 32'(bus.wr_addr), 32'd0);
      chk("mrst_data", 32'(bus.wr_data), 32'd0);
      chk("mrst_done", 32'(bus.cell_done), 32'd0);
      chk("mrst_err", 32'(bus.err_coord), 32'd0);
      chk("mrst_inrdy", 32'(bus.in_ready), 32'd1);
      load_f(16'h0D00);
      send_cell("after", 1, 1);
      collect("after", -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
